// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds FSM states, memory geometry and stream framing constants.
package imem_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_WIDTH = 32;
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write port bundle.
// slave: loader side (sinks bytes, drives writes); master: host/memory side.
interface imem_loader_if;

    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/imem_loader_word_asm.sv
// Little-endian word assembler: shifts bytes into lanes 0..3.
// Ports: clk, rst, shift_i/byte_i in; word_o (word incl. this byte), full_o (4th byte now).
module imem_word_assembler
    import imem_pkg::*;
#(
    parameter int WIDTH = IMEM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic             full_o
);

    localparam int CW = $clog2(WORD_BYTES);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (shift_i) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_i;
            // Wraps to 0 after the last lane, ready for the next word.
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign word_o = word_d;
    assign full_o = shift_i && (cnt_q == CW'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header (N words) + N LE words -> instruction memory writes.
// Ports: clk, rst, start, bus (imem_loader_if.slave), cpu_hold, done, error.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          DEPTH     = IMEM_DEPTH,
    parameter int          WIDTH     = IMEM_WIDTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    localparam int IW = $clog2(DEPTH) + 1;
    localparam int NW = HDR_BYTES * 8;

    loader_state_t    state_q, state_d;
    logic [NW-1:0]    n_q, n_d, n_full, idx_nxt;
    logic [IW-1:0]    idx_q, idx_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             xfer, word_full;
    logic [WIDTH-1:0] word_next;

    assign bus.byte_ready = (state_q == LEN0) || (state_q == LEN1) ||
                            (state_q == DATA);
    assign xfer    = bus.byte_valid && bus.byte_ready;
    assign n_full  = {bus.byte_data, n_q[7:0]};
    assign idx_nxt = NW'(idx_q) + NW'(1);

    imem_word_assembler #(.WIDTH(WIDTH)) u_asm (
        .clk     (clk),
        .rst     (rst),
        .shift_i (xfer && (state_q == DATA)),
        .byte_i  (bus.byte_data),
        .word_o  (word_next),
        .full_o  (word_full)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LEN0;
                    idx_d   = '0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LEN0: begin
                if (xfer) begin
                    n_d[7:0] = bus.byte_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    n_d = n_full;
                    if (n_full == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else if (n_full > NW'(DEPTH)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_full) begin
                    state_d = WRITE;
                    wr_en_d = 1'b1;
                    data_d  = word_next;
                    addr_d  = BASE_ADDR + 32'({idx_q, 2'b00});
                end
            end
            WRITE: begin
                idx_d = idx_q + IW'(1);
                if (idx_nxt == n_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;
    assign cpu_hold    = hold_q;
    assign done        = done_q;
    assign error       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader.
// Expected writes are queued at stimulus time and popped by a write monitor.
module tb_imem_loader;

    logic clk, rst, start;
    logic cpu_hold, done, error;

    imem_loader_if bus();

    imem_loader #(
        .DEPTH     (256),
        .WIDTH     (32),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    int          total = 0;
    int          bad   = 0;
    int          writes = 0;
    logic [63:0] sb[$];
    logic [63:0] mexp;
    logic [31:0] last_addr, last_data;
    logic [31:0] img [256];
    int          w0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.wr_en) begin
            writes++;
            last_addr = bus.wr_addr;
            last_data = bus.wr_data;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %0h data %0h, want none",
                         bus.wr_addr, bus.wr_data);
            end else begin
                mexp = sb.pop_front();
                chk("wr_addr", {32'h0, bus.wr_addr}, {32'h0, mexp[63:32]});
                chk("wr_data", {32'h0, bus.wr_data}, {32'h0, mexp[31:0]});
                chk("ready_in_write", {63'h0, bus.byte_ready}, 64'h0);
                chk("hold_in_write", {63'h0, cpu_hold}, 64'h1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat ($urandom_range(gap, 0)) @(negedge clk);
        @(negedge clk);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        n = 0;
        while (!bus.byte_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("byte_accept", {63'h0, bus.byte_ready}, 64'h1);
        @(posedge clk);
        #1 bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", {63'h0, done}, 64'h1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, {63'h0, bus.byte_ready}, 64'h0);
        chk({tag, "_wr_en"}, {63'h0, bus.wr_en}, 64'h0);
        chk({tag, "_wr_addr"}, {32'h0, bus.wr_addr}, 64'h0);
        chk({tag, "_wr_data"}, {32'h0, bus.wr_data}, 64'h0);
        chk({tag, "_hold"}, {63'h0, cpu_hold}, 64'h0);
        chk({tag, "_done"}, {63'h0, done}, 64'h0);
        chk({tag, "_error"}, {63'h0, error}, 64'h0);
    endtask

    // Reference: word k of the image lands at byte address 4*k.
    task automatic load_image(input int n, input int gap, input int start_at);
        int budget;
        for (int k = 0; k < n; k++)
            sb.push_back({32'(k * 4), img[k]});
        pulse_start();
        chk("hold_rise", {63'h0, cpu_hold}, 64'h1);
        chk("armed_done", {63'h0, done}, 64'h0);
        send_byte(8'(n), gap);
        send_byte(8'(n >> 8), gap);
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(8'(img[k] >> (8 * b)), gap);
                if (k * 4 + b == start_at) pulse_start();
            end
        end
        budget = (n == 0) ? 1 : 20 + n * 6 * (gap + 2);
        wait_done(budget);
        chk("load_error", {63'h0, error}, 64'h0);
        chk("load_hold", {63'h0, cpu_hold}, 64'h0);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        chk("idle_ready", {63'h0, bus.byte_ready}, 64'h0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Two-word load with random gaps.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        w0 = writes;
        load_image(2, 3, -1);
        chk("normal_writes", 64'(writes - w0), 64'd2);

        // Zero length: done the cycle after the header, no writes.
        w0 = writes;
        load_image(0, 0, -1);
        chk("zero_writes", 64'(writes - w0), 64'd0);

        // Oversize header: N = 257.
        w0 = writes;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        chk("over_done", {63'h0, done}, 64'h1);
        chk("over_error", {63'h0, error}, 64'h1);
        chk("over_hold", {63'h0, cpu_hold}, 64'h0);
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            chk("over_ready", {63'h0, bus.byte_ready}, 64'h0);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        chk("over_writes", 64'(writes - w0), 64'd0);
        pulse_start();
        chk("rearm_done", {63'h0, done}, 64'h0);
        chk("rearm_error", {63'h0, error}, 64'h0);
        chk("rearm_ready", {63'h0, bus.byte_ready}, 64'h1);
        chk("rearm_hold", {63'h0, cpu_hold}, 64'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Full depth, word k = k.
        for (int k = 0; k < 256; k++) img[k] = 32'(k);
        w0 = writes;
        load_image(256, 0, -1);
        chk("full_writes", 64'(writes - w0), 64'd256);
        chk("full_last_addr", {32'h0, last_addr}, 64'h3FC);
        chk("full_last_data", {32'h0, last_data}, 64'hFF);

        // Random loads with an ignored start pulse mid-data.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(12, 1);
            for (int k = 0; k < n; k++) img[k] = $urandom;
            w0 = writes;
            load_image(n, 2, $urandom_range(4 * n - 1, 0));
            chk("rand_writes", 64'(writes - w0), 64'(n));
        end

        // Reset after two bytes of word 1: word 1 must never be written.
        img[0] = $urandom;
        img[1] = $urandom;
        sb.push_back({32'h0, img[0]});
        pulse_start();
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        for (int b = 0; b < 4; b++) send_byte(8'(img[0] >> (8 * b)), 1);
        send_byte(8'(img[1]), 1);
        send_byte(8'(img[1] >> 8), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        chk("midrst_sb", 64'(sb.size()), 64'h0);
        rst = 1'b0;
        w0 = writes;
        repeat (4) @(negedge clk);
        chk("midrst_nowrite", 64'(writes - w0), 64'd0);
        img[0] = $urandom;
        img[1] = $urandom;
        load_image(2, 2, -1);
        chk("post_rst_writes", 64'(writes - w0), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
